shift_sequencer: RTL and testbench

//   Multi-cycle left-shift controller for the 16-bit datapath. It accepts an operand and a

---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_sequencer_if.sv | 37 +++
 rtl/shift_sequencer_sl1_stage.sv | 18 +
 rtl/shift_sequencer.sv | 100 ++++++++++
 tb/tb_shift_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// shift_seq_pkg -- shared constants for the shift_sequencer slice.
//   WIDTH_DEF / AMT_W_DEF : default operand and shift-amount widths
//   S_IDLE / S_SHIFT / S_DONE : FSM state encoding, also seen on dbg_state
package shift_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if -- request/response bundle of the shift sequencer.
//   start, operand, amount : request (accepted when start && ready)
//   ready                  : sequencer can take a request (IDLE only)
//   valid, result, ovf     : response; result/ovf qualified by valid
//   ack                    : consumer takes the response (acts only when valid)
// Handshake: a request transfers on a rising clk edge where start && ready are
// both high; a response transfers on a rising clk edge where valid && ack are
// both high. Neither side may make its own valid-type signal depend on the
// other side's ready-type signal in the same cycle.
// master = control unit / consumer side, slave = the sequencer.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
);

  logic             start;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             ready;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output start, operand, amount, ack,
    input  ready, valid, result, ovf
  );

  modport slave (
    input  start, operand, amount, ack,
    output ready, valid, result, ovf
  );

endinterface

// File: rtl/shift_sequencer_sl1_stage.sv
// sl1_stage -- combinational single-bit logical left shift.
//   din     : value to shift
//   dout    : {din[WIDTH-2:0], 1'b0}
//   msb_out : the bit shifted out (din[WIDTH-1])
module sl1_stage
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             msb_out
);

  assign dout    = {din[WIDTH-2:0], 1'b0};
  assign msb_out = din[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer -- multi-cycle left-shift controller.
// Accepts an operand and a shift amount, shifts the working register left by
// one bit per clock until the amount is consumed, then presents the result and
// a sticky overflow flag until acknowledged.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   bus       : shift_sequencer_if.slave (start/operand/amount/ready,
//               valid/ack/result/ovf)
//   dbg_state : current FSM state (S_IDLE / S_SHIFT / S_DONE)
// Optional feature macro SHIFT_SEQ_EARLY_DONE_EN: finish as soon as the
// working register is zero (zero operand at accept, or register shifted to
// zero). Outputs are the same either way; only latency changes.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  shift_sequencer_if.slave    bus,
  output logic [1:0]          dbg_state
);

  logic [1:0]       state_q;
  logic [AMT_W-1:0] count_q;
  logic [WIDTH-1:0] reg_q;
  logic             ovf_q;

  logic [WIDTH-1:0] shifted;
  logic             shifted_out;

  sl1_stage #(.WIDTH(WIDTH)) u_sl1 (
    .din     (reg_q),
    .dout    (shifted),
    .msb_out (shifted_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      reg_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            reg_q   <= bus.operand;
            count_q <= bus.amount;
            ovf_q   <= 1'b0;
`ifdef SHIFT_SEQ_EARLY_DONE_EN
            if (bus.operand == '0 || bus.amount == '0)
              state_q <= S_DONE;
            else
              state_q <= S_SHIFT;
`else
            if (bus.amount == '0)
              state_q <= S_DONE;
            else
              state_q <= S_SHIFT;
`endif
          end
        end

        S_SHIFT: begin
          reg_q   <= shifted;
          ovf_q   <= ovf_q | shifted_out;
          count_q <= count_q - AMT_W'(1);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
          // Once the register is zero every further shift is a no-op, so the
          // remaining count can be dropped without changing result or ovf.
          if (count_q == AMT_W'(1) || shifted == '0)
            state_q <= S_DONE;
`else
          if (count_q == AMT_W'(1))
            state_q <= S_DONE;
`endif
        end

        S_DONE: begin
          // start is deliberately not looked at here; the requester must
          // present it again once ready is high.
          if (bus.ack)
            state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.valid  = (state_q == S_DONE);
  assign bus.result = reg_q;
  assign bus.ovf    = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int W  = 16;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  shift_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];  // {ovf, result}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full-width product of operand * 2**amount; the low half is the
  // result and anything landing in the high half means a 1 was shifted out.
  function automatic logic [W:0] model(input logic [W-1:0] op, input logic [AW-1:0] amt);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, op} << amt;
    return {|full[2*W-1:W], full[W-1:0]};
  endfunction

  // Cycle (counting the accept cycle as 0) in which valid first shows.
  function automatic int model_lat(input logic [W-1:0] op, input logic [AW-1:0] amt);
    int n;
    n = int'(amt);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    if (op == '0) n = 0;
    else begin
      int p;
      p = 0;
      for (int b = W - 1; b >= 0; b--) if (op[b]) p = b;
      // after W-p shifts the lowest set bit has left the register
      if (W - p < n) n = W - p;
    end
`endif
    return n + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] op, input logic [AW-1:0] amt,
                        input int hold, input bit noise,
                        output int lat, output logic [W-1:0] res, output logic ovf);
    int guard;
    logic [W:0] exp;
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_start", 32'(bus.ready), 32'd1);
    exp_q.push_back(model(op, amt));
    bus.start   = 1'b1;
    bus.operand = op;
    bus.amount  = amt;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.operand = W'($urandom);
    bus.amount  = AW'($urandom);
    lat = 1;
    while (!bus.valid && lat < 40) begin
      if (noise) begin
        // start and ack outside IDLE/DONE must be ignored
        bus.start = 1'b1;
        bus.ack   = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    res = bus.result;
    ovf = bus.ovf;
    chk("latency", 32'(lat), 32'(model_lat(op, amt)));
    exp = exp_q.pop_front();
    chk("sb_result", 32'(res), 32'(exp[W-1:0]));
    chk("sb_ovf", 32'(ovf), 32'(exp[W]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.valid), 32'd1);
      chk("hold_result", 32'(bus.result), 32'(exp[W-1:0]));
      chk("hold_ovf", 32'(bus.ovf), 32'(exp[W]));
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("after_ack_ready", 32'(bus.ready), 32'd1);
    chk("after_ack_valid", 32'(bus.valid), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0]  op;
    logic [AW-1:0] amt;
    logic [W-1:0]  res;
    logic          ovf;
    int            lat;
    int            hold;
    bit            noise;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int            lat;
    logic [W-1:0]  res;
    logic          ovf;
    int            guard;

    bus.start   = 1'b0;
    bus.operand = '0;
    bus.amount  = '0;
    bus.ack     = 1'b0;
    reset       = 1'b1;

    tbl[0] = '{16'h9992, 4'd1,  16'h3324, 1'b1, 2,  0, 1'b0};
    tbl[1] = '{16'h1082, 4'd3,  16'h8410, 1'b0, 4,  1, 1'b0};
    tbl[2] = '{16'hFFFF, 4'd15, 16'h8000, 1'b1, 16, 0, 1'b1};
    tbl[3] = '{16'h7BF6, 4'd0,  16'h7BF6, 1'b0, 1,  5, 1'b0};
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    tbl[4] = '{16'h0000, 4'd9,  16'h0000, 1'b0, 1,  0, 1'b0};
`else
    tbl[4] = '{16'h0000, 4'd9,  16'h0000, 1'b0, 10, 0, 1'b0};
`endif

    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].op, tbl[i].amt, tbl[i].hold, tbl[i].noise, lat, res, ovf);
      chk("tbl_lat", 32'(lat), 32'(tbl[i].lat));
      chk("tbl_result", 32'(res), 32'(tbl[i].res));
      chk("tbl_ovf", 32'(ovf), 32'(tbl[i].ovf));
    end

    // reset in the middle of a shift abandons the operation
    bus.start   = 1'b1;
    bus.operand = 16'h0001;
    bus.amount  = 4'd8;
    @(negedge clk);             // cycle 1
    bus.start = 1'b0;
    repeat (3) @(negedge clk);  // cycle 4
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_ovf", 32'(bus.ovf), 32'd0);
    run_op(16'h0003, 4'd2, 0, 1'b0, lat, res, ovf);
    chk("postrst_result", 32'(res), 32'h000C);

    // ack and start together in DONE: result consumed, start not taken
    bus.start   = 1'b1;
    bus.operand = 16'h00F0;
    bus.amount  = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("ackstart_valid", 32'(bus.valid), 32'd1);
    chk("ackstart_result", 32'(bus.result), 32'h03C0);
    bus.ack     = 1'b1;
    bus.start   = 1'b1;
    bus.operand = 16'h1234;
    bus.amount  = 4'd1;
    @(negedge clk);
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    chk("ackstart_idle", 32'(bus.ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("ackstart_not_taken_ready", 32'(bus.ready), 32'd1);
    chk("ackstart_not_taken_valid", 32'(bus.valid), 32'd0);
    chk("idle_holds_result", 32'(bus.result), 32'h03C0);

    // randomized operations against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0]  op;
      logic [AW-1:0] amt;
      logic [W:0]    m;
      op  = W'($urandom);
      if (r % 8 == 3) op = W'(16'h8000 >> $urandom_range(0, 15));
      amt = AW'($urandom_range(0, 15));
      m   = model(op, amt);
      run_op(op, amt, $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat, res, ovf);
      chk("rand_result", 32'(res), 32'(m[W-1:0]));
      chk("rand_ovf", 32'(ovf), 32'(m[W]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
